// File: rtl/irom_axi_rslv_if.sv
// AXI4 read-address and read-data channels between an instruction-fetch master
// and the irom_axi_rslv responder.
interface irom_axi_rslv_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [3:0]            arregion;

    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst,
               arlock, arcache, arprot, arqos, arregion, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst,
               arlock, arcache, arprot, arqos, arregion, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/irom_axi_rslv.sv
// AXI4 read-only instruction memory responder: one AR at a time, FIXED/INCR/WRAP
// bursts on R, plus a backdoor load port for writing program images.
module irom_axi_rslv #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    localparam int                   IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    irom_axi_rslv_if.slave        axi,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    typedef enum logic [0:0] {
        IDLE,
        BURST
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] wrap_lo_q, wrap_lo_d;
    logic [ADDR_WIDTH-1:0] wrap_hi_q, wrap_hi_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  start_err;
    logic [ADDR_WIDTH-1:0] ar_total;
    logic [ADDR_WIDTH-1:0] ar_wrap_lo;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_oob;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] rd_word;

    logic unused_ar;
    assign unused_ar = ^{axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion};

    // Whole-burst errors are decided once, from the request itself.
    always_comb begin
        start_err  = (axi.arsize > 3'd2)
                  || (axi.arburst == 2'b11)
                  || ((axi.arburst == BURST_WRAP)
                      && !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
        ar_total   = (ADDR_WIDTH'(axi.arlen) + ONE_A) << axi.arsize;
        ar_wrap_lo = axi.araddr & ~(ar_total - ONE_A);
    end

    always_comb begin
        incr_addr = addr_q + (ONE_A << size_q);
        unique case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (incr_addr == wrap_hi_q) ? wrap_lo_q : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

    // The rdata register is loaded either with the first beat at AR handshake
    // or with the following beat on an R handshake, so one read port serves both.
    always_comb begin
        rd_addr = (state_q == IDLE) ? axi.araddr : next_addr;
        rd_idx  = (rd_addr - BASE_ADDR) >> 2;
        rd_oob  = (rd_addr < BASE_ADDR) || (rd_idx >= DEPTH_A);
        rd_err  = rd_oob || ((state_q == IDLE) ? start_err : err_q);
        rd_word = rd_err ? '0 : mem[rd_idx[IDX_W-1:0]];
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        wrap_lo_d = wrap_lo_q;
        wrap_hi_d = wrap_hi_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    state_d   = BURST;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (axi.arlen == 8'd0);
                    rid_d     = axi.arid;
                    rdata_d   = rd_word;
                    rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    addr_d    = axi.araddr;
                    wrap_lo_d = ar_wrap_lo;
                    wrap_hi_d = ar_wrap_lo + ar_total;
                    size_d    = axi.arsize;
                    burst_d   = axi.arburst;
                    cnt_d     = axi.arlen;
                    err_d     = start_err;
                end
            end
            BURST: begin
                if (rvalid_q && axi.rready) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = next_addr;
                        rlast_d = (cnt_q == 8'd1);
                        rdata_d = rd_word;
                        rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            wrap_lo_q <= '0;
            wrap_hi_q <= '0;
            size_q    <= '0;
            burst_q   <= BURST_INCR;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            wrap_lo_q <= wrap_lo_d;
            wrap_hi_q <= wrap_hi_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the memory array has no reset so it maps onto RAM and keeps the
    // loaded image across rst; a read in the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

endmodule

// File: tb/tb_irom_axi_rslv.sv
// Self-checking bench for irom_axi_rslv: directed scenarios plus randomized
// bursts compared against an address-arithmetic reference model.
module tb_irom_axi_rslv;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  INCR  = 2'b01;
    localparam logic [1:0]  WRAP  = 2'b10;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    beat_t       exp_q [$];

    always #5 clk = ~clk;

    irom_axi_rslv_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) bus ();

    irom_axi_rslv #(
        .ID_WIDTH  (4),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .axi      (bus),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats straight from the address rules: beat i of a burst sits at
    // start + i*S (INCR), start (FIXED) or the start offset rotated inside the
    // aligned wrap window (WRAP).
    function automatic void model_burst(input logic [31:0] addr, input logic [7:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] s, total, lower, a, start, idx;
        bit          all_err, oob;
        beat_t       b;
        exp_q.delete();
        start   = {32'h0, addr};
        s       = 64'd1 << size;
        total   = ({56'h0, len} + 64'd1) * s;
        lower   = start - (start % total);
        all_err = (size > 3'd2) || (burst == 2'b11)
               || (burst == WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                FIXED:   a = start;
                WRAP:    a = lower + ((start - lower + 64'(i) * s) % total);
                default: a = (start + 64'(i) * s) % (64'd1 << 32);
            endcase
            idx    = (a - {32'h0, BASE}) / 64'd4;
            oob    = (a < {32'h0, BASE}) || (idx >= 64'(DEPTH));
            b.resp = (all_err || oob) ? 2'b10 : 2'b00;
            b.data = (all_err || oob) ? 32'h0 : model_mem[idx[9:0]];
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endfunction

    task automatic load_word(input int idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = 10'(idx);
        load_data = data;
        step();
        load_en    = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic issue_ar(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.arvalid  = 1'b1;
        bus.arid     = id;
        bus.araddr   = addr;
        bus.arlen    = len;
        bus.arsize   = size;
        bus.arburst  = burst;
        bus.arlock   = 1'($urandom);
        bus.arcache  = 4'($urandom);
        bus.arprot   = 3'($urandom);
        bus.arqos    = 4'($urandom);
        bus.arregion = 4'($urandom);
        while (bus.arready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "/arready"}, bus.arready, 1'b1);
        step();
        bus.arvalid = 1'b0;
        bus.arid    = 4'($urandom);
        bus.araddr  = $urandom;
        bus.arlen   = 8'($urandom);
        check({tag, "/arready_low"}, bus.arready, 1'b0);
    endtask

    task automatic run_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                            input int stall0, input bit rnd_stall);
        logic [31:0] d;
        logic [6:0]  side;
        model_burst(addr, len, size, burst);
        issue_ar(tag, id, addr, len, size, burst);
        foreach (exp_q[i]) begin
            int hold;
            if (i == 0) hold = stall0;
            else if (rnd_stall && $urandom_range(0, 2) == 0) hold = int'($urandom_range(1, 3));
            else hold = 0;
            if (hold > 0) begin
                bus.rready = 1'b0;
                d    = bus.rdata;
                side = {bus.rresp, bus.rlast, bus.rid};
                for (int h = 0; h < hold; h++) begin
                    step();
                    check({tag, "/hold_rvalid"}, bus.rvalid, 1'b1);
                    check({tag, "/hold_rdata"}, bus.rdata, d);
                    check({tag, "/hold_resp_last_id"}, {bus.rresp, bus.rlast, bus.rid}, side);
                end
            end
            bus.rready = 1'b1;
            check({tag, "/rvalid"}, bus.rvalid, 1'b1);
            check({tag, "/rdata"}, bus.rdata, exp_q[i].data);
            check({tag, "/rresp"}, bus.rresp, exp_q[i].resp);
            check({tag, "/rlast"}, bus.rlast, exp_q[i].last);
            check({tag, "/rid"}, bus.rid, id);
            step();
        end
        bus.rready = 1'b0;
        check({tag, "/end_rvalid"}, bus.rvalid, 1'b0);
        check({tag, "/end_arready"}, bus.arready, 1'b1);
    endtask

    initial begin
        logic [31:0] nw1, nw3;
        logic [31:0] raddr;
        logic [7:0]  rlen;
        logic [2:0]  rsize;
        logic [1:0]  rburst;

        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = 3'd2;
        bus.arburst = INCR;
        bus.arlock  = 1'b0;
        bus.arcache = '0;
        bus.arprot  = '0;
        bus.arqos   = '0;
        bus.arregion = '0;
        bus.rready  = 1'b0;
        step();
        step();

        check("reset/arready", bus.arready, 1'b0);
        check("reset/rvalid", bus.rvalid, 1'b0);
        check("reset/rlast", bus.rlast, 1'b0);
        check("reset/rid", bus.rid, 4'h0);
        check("reset/rdata", bus.rdata, 32'h0);
        check("reset/rresp", bus.rresp, 2'b00);

        // Whole image is written while rst is still held.
        for (int i = 0; i < DEPTH; i++) begin
            load_en      = 1'b1;
            load_addr    = 10'(i);
            load_data    = $urandom;
            model_mem[i] = load_data;
            step();
        end
        load_en = 1'b0;
        check("reset/arready_during_load", bus.arready, 1'b0);

        rst = 1'b0;
        step();
        check("post_reset/arready", bus.arready, 1'b1);
        check("post_reset/rvalid", bus.rvalid, 1'b0);

        run_read("load_in_reset", 4'h1, 32'h0000_0030, 8'd2, 3'd2, INCR, 0, 1'b0);

        load_word(5, 32'hDEAD_BEEF);
        run_read("single", 4'h3, 32'h0000_0014, 8'd0, 3'd2, INCR, 0, 1'b0);

        for (int i = 0; i < 4; i++) load_word(i, 32'h10 + 32'(i));
        run_read("incr4", 4'h1, 32'h0000_0000, 8'd3, 3'd2, INCR, 0, 1'b0);

        for (int i = 0; i < 4; i++) load_word(i, 32'hA0 + 32'(i));
        run_read("wrap4", 4'h2, 32'h0000_0008, 8'd3, 3'd2, WRAP, 0, 1'b0);
        run_read("wrap8_half", 4'h4, 32'h0000_0104, 8'd7, 3'd1, WRAP, 0, 1'b0);

        run_read("backpressure", 4'h5, 32'h0000_0040, 8'd1, 3'd2, INCR, 3, 1'b0);

        run_read("err_top", 4'h6, 32'(DEPTH * 4 - 4), 8'd1, 3'd2, INCR, 0, 1'b0);
        run_read("err_size3", 4'h7, 32'h0000_0020, 8'd3, 3'd3, INCR, 0, 1'b0);
        run_read("err_burst11", 4'h8, 32'h0000_0020, 8'd1, 3'd2, 2'b11, 0, 1'b0);
        run_read("err_wrap_len2", 4'h9, 32'h0000_0020, 8'd2, 3'd2, WRAP, 0, 1'b0);
        run_read("addr_rollover", 4'hA, 32'hFFFF_FFFC, 8'd1, 3'd2, INCR, 0, 1'b0);
        run_read("fixed_byte", 4'hB, 32'h0000_0051, 8'd2, 3'd0, FIXED, 1, 1'b0);

        // Loads racing the beat pipeline: same-edge load yields the old word,
        // a load one edge earlier is visible.
        model_burst(32'h0000_0200, 8'd3, 3'd2, INCR);
        issue_ar("ld_race", 4'hC, 32'h0000_0200, 8'd3, 3'd2, INCR);
        bus.rready = 1'b1;
        nw1 = $urandom;
        nw3 = $urandom;
        load_en   = 1'b1;
        load_addr = 10'd129;
        load_data = nw1;
        check("ld_race/beat0", bus.rdata, exp_q[0].data);
        step();
        model_mem[129] = nw1;
        load_addr = 10'd131;
        load_data = nw3;
        check("ld_race/beat1_old", bus.rdata, exp_q[1].data);
        step();
        load_en = 1'b0;
        model_mem[131] = nw3;
        check("ld_race/beat2", bus.rdata, exp_q[2].data);
        step();
        check("ld_race/beat3_new", bus.rdata, nw3);
        check("ld_race/beat3_last", bus.rlast, 1'b1);
        step();
        bus.rready = 1'b0;
        run_read("ld_race_reread", 4'hD, 32'h0000_0204, 8'd0, 3'd2, INCR, 0, 1'b0);

        // Reset in the middle of an 8-beat burst.
        model_burst(32'h0000_0100, 8'd7, 3'd2, INCR);
        issue_ar("rst_mid", 4'h9, 32'h0000_0100, 8'd7, 3'd2, INCR);
        bus.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid/beat_data", bus.rdata, exp_q[i].data);
            step();
        end
        check("rst_mid/beat3_shown", bus.rvalid, 1'b1);
        rst = 1'b1;
        step();
        check("rst_mid/rvalid_cut", bus.rvalid, 1'b0);
        check("rst_mid/rlast_cut", bus.rlast, 1'b0);
        check("rst_mid/arready_in_rst", bus.arready, 1'b0);
        bus.rready = 1'b0;
        rst = 1'b0;
        step();
        check("rst_mid/arready_after", bus.arready, 1'b1);
        check("rst_mid/rvalid_after", bus.rvalid, 1'b0);
        run_read("after_rst", 4'hE, 32'h0000_0300, 8'd0, 3'd2, INCR, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            rsize  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            rburst = 2'($urandom_range(0, 3));
            if (rburst == WRAP && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0:       rlen = 8'd1;
                    1:       rlen = 8'd3;
                    2:       rlen = 8'd7;
                    default: rlen = 8'd15;
                endcase
            end else begin
                rlen = 8'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 4) == 0) raddr = 32'(DEPTH * 4) - 32'($urandom_range(0, 40));
            else raddr = 32'($urandom_range(0, DEPTH * 4 - 1));
            if (rburst == WRAP) raddr = raddr & ~((32'd1 << rsize) - 32'd1);
            run_read("random", 4'($urandom), raddr, rlen, rsize, rburst,
                     int'($urandom_range(0, 2)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
